// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, MEM/WB stage state encoding and
// small decode helpers used by the execute and memory/write-back stages.
package cpu_pkg;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_AND = 6'b000010;
    localparam logic [5:0] OP_OR  = 6'b000011;
    localparam logic [5:0] OP_XOR = 6'b000100;
    localparam logic [5:0] OP_SLT = 6'b000101;
    localparam logic [5:0] OP_SW  = 6'b010000;
    localparam logic [5:0] OP_LW  = 6'b010001;
    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_JMP = 6'b100001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WB   = 2'd2
    } stage_state_e;

    function automatic logic is_alu_op(input logic [5:0] op);
        return (op[5:3] == 3'b000) && (op[2:0] <= 3'd5);
    endfunction

    function automatic logic writes_back(input logic [5:0] op);
        return is_alu_op(op) || (op == OP_LW);
    endfunction

    function automatic logic [31:0] next_pc(input logic [5:0]  op,
                                            input logic        ife,
                                            input logic [31:0] target,
                                            input logic [31:0] seq_pc);
        logic [31:0] pc;
        case (op)
            OP_JMP:  pc = target;
            OP_BEQ:  pc = ife ? target : seq_pc;
            default: pc = seq_pc;
        endcase
        return pc;
    endfunction

endpackage

// File: rtl/dmem.sv
// Single-port synchronous data RAM with registered read data; contents are
// deliberately not reset.
module dmem #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [MEM_DEPTH];

    // write port and registered read port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: IDLE -> MEM -> WB sequencer that performs
// loads/stores, returns write-back data and computes the next fetch PC.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [5:0]  ex_op,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_addr,
    input  logic        ex_ife,
    input  logic [31:0] ex_pc,
    output logic        reg_update,
    output logic [31:0] reg_i,
    output logic        pc_load,
    output logic [31:0] pc_o,
    output logic        done,
    output logic        ovr_err
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    stage_state_e r_state;
    logic [5:0]   r_op;
    logic [31:0]  r_alu;
    logic [31:0]  r_addr;
    logic [31:0]  r_pc;
    logic         r_ife;
    logic         r_ready;
    logic         r_reg_update;
    logic         r_pc_load;
    logic         r_done;
    logic         r_ovr_err;
    logic [31:0]  r_reg_i;
    logic [31:0]  r_pc_o;

    logic          w_mem_we;
    logic [AW-1:0] w_word;
    logic [31:0]   w_rdata;

    // RAM is addressed from the live inputs in IDLE so load data is ready during MEM
    always_comb begin
        w_word = r_addr[AW+1:2];
        if (r_state == ST_IDLE) begin
            w_word = ex_addr[AW+1:2];
        end else begin
            w_word = r_addr[AW+1:2];
        end
    end

    assign w_mem_we = (r_state == ST_MEM) && (r_op == OP_SW) && rst_n;

    dmem #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_word),
        .i_wdata (r_alu),
        .o_rdata (w_rdata)
    );

    // stage sequencer, input latches and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_op         <= 6'd0;
            r_alu        <= 32'd0;
            r_addr       <= 32'd0;
            r_pc         <= 32'd0;
            r_ife        <= 1'b0;
            r_ready      <= 1'b1;
            r_reg_update <= 1'b0;
            r_pc_load    <= 1'b0;
            r_done       <= 1'b0;
            r_ovr_err    <= 1'b0;
            r_reg_i      <= 32'd0;
            r_pc_o       <= RESET_PC;
        end else begin
            if (ex_valid && (r_state != ST_IDLE)) begin
                r_ovr_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_reg_update <= 1'b0;
                    r_pc_load    <= 1'b0;
                    r_done       <= 1'b0;
                    if (ex_valid) begin
                        r_op    <= ex_op;
                        r_alu   <= ex_alu;
                        r_addr  <= ex_addr;
                        r_ife   <= ex_ife;
                        r_pc    <= ex_pc;
                        r_ready <= 1'b0;
                        r_state <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    r_state      <= ST_WB;
                    r_done       <= 1'b1;
                    r_pc_load    <= 1'b1;
                    r_reg_update <= writes_back(r_op);
                    r_pc_o       <= next_pc(r_op, r_ife, r_addr, r_pc);
                    if (writes_back(r_op)) begin
                        r_reg_i <= (r_op == OP_LW) ? w_rdata : r_alu;
                    end
                end
                ST_WB: begin
                    r_state      <= ST_IDLE;
                    r_ready      <= 1'b1;
                    r_reg_update <= 1'b0;
                    r_pc_load    <= 1'b0;
                    r_done       <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_ready      <= 1'b1;
                    r_reg_update <= 1'b0;
                    r_pc_load    <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign ex_ready   = r_ready;
    assign reg_update = r_reg_update;
    assign reg_i      = r_reg_i;
    assign pc_load    = r_pc_load;
    assign pc_o       = r_pc_o;
    assign done       = r_done;
    assign ovr_err    = r_ovr_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed test-plan steps followed by
// randomized transactions checked against a behavioural model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [5:0]  ex_op;
    logic [31:0] ex_alu;
    logic [31:0] ex_addr;
    logic        ex_ife;
    logic [31:0] ex_pc;
    logic        reg_update;
    logic [31:0] reg_i;
    logic        pc_load;
    logic [31:0] pc_o;
    logic        done;
    logic        ovr_err;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    logic [31:0] m_mem [256];
    bit          m_wr  [256];
    logic [31:0] m_reg_i;
    bit          m_reg_known;
    logic [31:0] m_pc;
    bit          m_ovr;

    mem_wb_stage #(.MEM_DEPTH(256), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_op      (ex_op),
        .ex_alu     (ex_alu),
        .ex_addr    (ex_addr),
        .ex_ife     (ex_ife),
        .ex_pc      (ex_pc),
        .reg_update (reg_update),
        .reg_i      (reg_i),
        .pc_load    (pc_load),
        .pc_o       (pc_o),
        .done       (done),
        .ovr_err    (ovr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, ex_ready}, 32'd1);
        chk({tag, "_regupd"}, {31'd0, reg_update}, 32'd0);
        chk({tag, "_pcload"}, {31'd0, pc_load}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_ovr"}, {31'd0, ovr_err}, {31'd0, m_ovr});
        chk({tag, "_pc"}, pc_o, m_pc);
        if (m_reg_known) chk({tag, "_regi"}, reg_i, m_reg_i);
    endtask

    task automatic model_reset();
        m_reg_i     = 32'd0;
        m_reg_known = 1'b1;
        m_pc        = 32'h0;
        m_ovr       = 1'b0;
    endtask

    // one full transaction; overrun re-asserts ex_valid during MEM, check_rd
    // clear means the loaded value is not predicted
    task automatic run_txn(input string tag, input logic [5:0] op, input logic [31:0] alu,
                           input logic [31:0] addr, input logic ife, input logic [31:0] pc,
                           input bit overrun, input bit check_rd);
        int          idx;
        bit          wb;
        logic [31:0] exp_pc;
        idx    = int'((addr >> 2) % 32'd256);
        wb     = (op <= 6'd5) || (op == 6'h11);
        exp_pc = (op == 6'h21 || (op == 6'h20 && ife)) ? addr : pc;

        @(negedge clk);
        ex_valid = 1'b1; ex_op = op; ex_alu = alu; ex_addr = addr; ex_ife = ife; ex_pc = pc;
        @(posedge clk);
        @(negedge clk);
        if (overrun) begin
            ex_valid = 1'b1; ex_op = 6'h21; ex_alu = $urandom(); ex_addr = $urandom();
            ex_pc = $urandom(); ex_ife = 1'b1;
        end else begin
            ex_valid = 1'b0;
        end
        chk({tag, "_mem_ready"}, {31'd0, ex_ready}, 32'd0);
        chk({tag, "_mem_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_mem_regupd"}, {31'd0, reg_update}, 32'd0);

        @(negedge clk);
        ex_valid = 1'b0;
        if (overrun) m_ovr = 1'b1;
        if (op == 6'h10) begin
            m_mem[idx] = alu;
            m_wr[idx]  = 1'b1;
        end
        if (wb) begin
            if (op == 6'h11) begin
                m_reg_known = check_rd && m_wr[idx];
                m_reg_i     = m_mem[idx];
            end else begin
                m_reg_known = 1'b1;
                m_reg_i     = alu;
            end
        end
        m_pc = exp_pc;
        chk({tag, "_wb_ready"}, {31'd0, ex_ready}, 32'd0);
        chk({tag, "_wb_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_wb_pcload"}, {31'd0, pc_load}, 32'd1);
        chk({tag, "_wb_regupd"}, {31'd0, reg_update}, {31'd0, wb});
        chk({tag, "_wb_pc"}, pc_o, m_pc);
        chk({tag, "_wb_ovr"}, {31'd0, ovr_err}, {31'd0, m_ovr});
        if (m_reg_known) chk({tag, "_wb_regi"}, reg_i, m_reg_i);

        @(negedge clk);
        chk_idle_outputs({tag, "_after"});
    endtask

    initial begin
        int          r;
        logic [5:0]  op;
        logic [31:0] a;
        logic [3:0]  idx4;
        logic [5:0]  unk [4];
        unk[0] = 6'h06; unk[1] = 6'h12; unk[2] = 6'h22; unk[3] = 6'h3F;
        for (int i = 0; i < 256; i++) m_wr[i] = 1'b0;

        rst_n = 1'b0; ex_valid = 1'b0; ex_op = 6'd0; ex_alu = 32'd0;
        ex_addr = 32'd0; ex_ife = 1'b0; ex_pc = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("post_reset");

        run_txn("add",      6'h00, 32'h7,        32'h0,   1'b0, 32'h4, 1'b0, 1'b1);
        run_txn("sw",       6'h10, 32'hDEADBEEF, 32'h10,  1'b0, 32'h8, 1'b0, 1'b1);
        run_txn("lw",       6'h11, 32'h0,        32'h10,  1'b0, 32'hC, 1'b0, 1'b1);
        run_txn("lw_wrap",  6'h11, 32'h0,        32'h410, 1'b0, 32'h10, 1'b0, 1'b1);
        run_txn("beq_t",    6'h20, 32'h0,        32'h40,  1'b1, 32'h8, 1'b0, 1'b1);
        run_txn("beq_nt",   6'h20, 32'h0,        32'h40,  1'b0, 32'h8, 1'b0, 1'b1);
        run_txn("jmp",      6'h21, 32'h0,        32'h100, 1'b0, 32'h8, 1'b0, 1'b1);
        run_txn("overrun",  6'h00, 32'h1234,     32'h0,   1'b0, 32'h20, 1'b1, 1'b1);
        run_txn("unknown",  6'h3F, 32'h55,       32'h200, 1'b1, 32'h24, 1'b0, 1'b1);

        // reset during MEM of SW 0x20 <- 0x5
        @(negedge clk);
        ex_valid = 1'b1; ex_op = 6'h10; ex_alu = 32'h5; ex_addr = 32'h20; ex_pc = 32'h30;
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        #1;
        chk_idle_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rst_mid_after");
        run_txn("lw_after_rst", 6'h11, 32'h0, 32'h20, 1'b0, 32'h34, 1'b0, 1'b0);
        checks++;
        assert (reg_i !== 32'h5) else begin
            failures++;
            $error("FAIL rst_sw_suppressed observed=0x%08h expected=not 0x00000005", reg_i);
        end

        // randomized: seed 16 words, then mixed traffic
        for (int i = 0; i < 16; i++) begin
            a = $urandom(); a[9:2] = 8'(i);
            run_txn("rnd_seed", 6'h10, $urandom(), a, 1'b0, $urandom(), 1'b0, 1'b1);
        end
        for (int n = 0; n < 150; n++) begin
            r    = $urandom_range(0, 9);
            idx4 = 4'($urandom_range(0, 15));
            a    = $urandom();
            case (r)
                0, 1, 2, 3, 4, 5: op = 6'(r);
                6: begin op = 6'h10; a[9:2] = {4'd0, idx4}; end
                7: begin op = 6'h11; a[9:2] = {4'd0, idx4}; end
                8: op = ($urandom_range(0, 1) == 0) ? 6'h20 : 6'h21;
                default: op = unk[$urandom_range(0, 3)];
            endcase
            run_txn("rnd", op, $urandom(), a, 1'($urandom_range(0, 1)), $urandom(),
                    ($urandom_range(0, 15) == 0), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
